// File: rtl/bcd_pkg.sv
// Shared types for the serial BCD adder/subtractor: digit type, FSM states,
// and the nine's-complement helper used by both the CALC and FIX passes.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One decimal digit of addition with carry: s = x + y + c, decimal-adjusted
// by +6 whenever the binary sum exceeds 9.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       c,
  output bcd_digit_t digit,
  output logic       carry
);

  logic [4:0] sum_s;

  // Binary digit sum followed by decimal adjust
  always_comb begin
    sum_s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (sum_s > 5'd9) begin
      digit = sum_s[3:0] + 4'd6;
      carry = 1'b1;
    end else begin
      digit = sum_s[3:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction uses nine's complement; a negative raw result is recomplemented
// in a second serial pass (FIX). Optional invalid-digit flag: BCD_DIGIT_CHECK_EN.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] result,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int W     = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             neg_q, neg_d;

  bcd_digit_t       step_x_s, step_y_s, step_digit_s;
  logic             step_c_s, step_carry_s;
  logic [W-1:0]     sum_shift_s;
  logic             accept_s;
  logic             done_enter_s;
  logic             last_s;

  bcd_digit_step u_step (
    .x     (step_x_s),
    .y     (step_y_s),
    .c     (step_c_s),
    .digit (step_digit_s),
    .carry (step_carry_s)
  );

  assign accept_s     = in_valid & (state_q == IDLE);
  assign done_enter_s = (state_q != DONE) & (state_d == DONE);
  assign last_s       = (idx_q == IDX_LAST);
  // New digit enters at the top so the finished word is in natural order
  assign sum_shift_s  = (W'(step_digit_s) << (W - 4)) | (sum_q >> 4);

  // Next-state, datapath steering and result capture
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    cout_d   = cout_q;
    neg_d    = neg_q;
    step_x_s = a_q[3:0];
    step_y_s = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];
    step_c_s = carry_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = sum_shift_s;
        carry_d = step_carry_s;
        if (last_s) begin
          if (!sub_q || step_carry_s) begin
            state_d  = DONE;
            result_d = sum_shift_s;
            cout_d   = step_carry_s;
            neg_d    = 1'b0;
          end else begin
            // a < b: raw sum is 10^N + a - b, recomplement it
            state_d = FIX;
            idx_d   = '0;
            carry_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      FIX: begin
        step_x_s = 4'd0;
        step_y_s = nines_comp(sum_q[3:0]);
        sum_d    = sum_shift_s;
        carry_d  = step_carry_s;
        if (last_s) begin
          state_d  = DONE;
          result_d = sum_shift_s;
          cout_d   = 1'b0;
          neg_d    = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, shift and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign neg       = neg_q;

`ifdef BCD_DIGIT_CHECK_EN
  logic in_bad_s;
  logic err_pend_q;
  logic err_q;

  // Any nibble above 9 in either operand
  always_comb begin
    in_bad_s = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      in_bad_s = in_bad_s | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end
  end

  // Flag latched at acceptance, published alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept_s) begin
        err_pend_q <= in_bad_s;
      end
      if (done_enter_s) begin
        err_q <= err_pend_q;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: directed corner cases plus random
// BCD operands, checked against an integer-arithmetic reference model.
module tb_bcd_addsub_serial;

  localparam int N   = 4;
  localparam int W   = 4 * N;
  localparam int POW = 10000;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    bit           cout;
    bit           neg;
    bit           err;
    int           lat;
    bit           chk_res;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic         cout, neg, err;
  logic [W-1:0] a, b, result;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   was_valid = 1'b0;

  bcd_addsub_serial #(.N_DIGITS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .neg(neg), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int i = 0; i < N; i++) bad = bad | (v[4*i +: 4] > 4'd9);
    return bad;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input bit s);
    exp_t e;
    int x = bcd2int(av);
    int y = bcd2int(bv);
    e.err     = CHK_EN & (has_bad(av) | has_bad(bv));
    e.chk_res = !(has_bad(av) | has_bad(bv));
    if (!s) begin
      e.res  = int2bcd((x + y) % POW);
      e.cout = (x + y) >= POW;
      e.neg  = 1'b0;
      e.lat  = N;
    end else if (x >= y) begin
      e.res  = int2bcd(x - y);
      e.cout = 1'b1;
      e.neg  = 1'b0;
      e.lat  = N;
    end else begin
      e.res  = int2bcd(y - x);
      e.cout = 1'b0;
      e.neg  = 1'b1;
      e.lat  = 2 * N;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: pops an expectation when a result appears, then checks it holds
  always @(negedge clk) begin
    if (rst) begin
      was_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!was_valid) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 64'(out_valid), 64'd0);
          end else begin
            cur = q.pop_front();
            check("err", 64'(err), 64'(cur.err));
            if (cur.chk_res) begin
              check("result", 64'(result), 64'(cur.res));
              check("cout", 64'(cout), 64'(cur.cout));
              check("neg", 64'(neg), 64'(cur.neg));
              check("latency", 64'(cyc - last_acc), 64'(cur.lat));
            end
          end
        end else if (cur.chk_res) begin
          check("hold_result", 64'(result), 64'(cur.res));
          check("hold_flags", 64'({cout, neg, err}), 64'({cur.cout, cur.neg, cur.err}));
        end
        check("in_ready_in_done", 64'(in_ready), 64'd0);
      end
      was_valid = out_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit s, input bit expect_out);
    @(negedge clk);
    wait_idle();
    a = av;
    b = bv;
    sub = s;
    in_valid = 1'b1;
    if (expect_out) q.push_back(model(av, bv, s));
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit s, input int hold);
    int n = 0;
    issue(av, bv, s, 1'b1);
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 64'(out_valid), 64'd1);
    end else begin
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("consumed", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_outputs", 64'({out_valid, cout, neg, err}), 64'd0);
    check("reset_result", 64'(result), 64'd0);

    do_op(16'h9999, 16'h0001, 1'b0, 0);
    do_op(16'h0500, 16'h0123, 1'b1, 1);
    do_op(16'h0123, 16'h0500, 1'b1, 0);
    do_op(16'h4567, 16'h5678, 1'b0, 5);
    do_op(16'h0777, 16'h0777, 1'b1, 0);

    // Abort in the second CALC cycle
    issue(16'h8888, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({out_valid, cout, neg, err}), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(negedge clk);
    check("abort_no_valid", 64'(out_valid), 64'd0);
    do_op(16'h1234, 16'h1111, 1'b0, 0);

    do_op(16'h00A0, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      do_op(rand_bcd(), rand_bcd(), 1'($urandom), int'($urandom_range(0, 3)));
    end

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
